// File: rtl/multi_alarm_adjust.sv
// multi_alarm_adjust: editor for the clock time and NUM_ALARMS alarm channels.
// A cursor walks every hours/minutes field. Up/down auto-repeat while held.
// A one-cycle commit pulse hands the edited shadow values to the
// timekeeper and the alarm comparators.
module multi_alarm_adjust #(
  parameter int NUM_ALARMS   = 2,
  parameter int HOUR_MAX     = 24,
  parameter int CARRY_EN     = 1,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  localparam int NCH    = NUM_ALARMS + 1,
  localparam int NFIELD = 2 * NCH,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [4:0]        btn,
  input  logic [5*NCH-1:0]  hours_in,
  input  logic [6*NCH-1:0]  minutes_in,
  output logic [5*NCH-1:0]  hours_out,
  output logic [6*NCH-1:0]  minutes_out,
  output logic              commit,
  output logic [NCH-1:0]    dirty,
  output logic [2:0]        sel_tens,
  output logic [3:0]        sel_units,
  output logic [CHW-1:0]    sel_channel,
  output logic              sel_is_min,
  output logic [NFIELD-1:0] led
);

  localparam int FW      = $clog2(NFIELD);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DELAY_C    = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RATE_C     = CW'(REPEAT_RATE);
  localparam logic [4:0]    HOUR_LAST  = 5'(HOUR_MAX - 1);
  localparam logic [5:0]    HOUR_LIM   = 6'(HOUR_MAX);
  localparam logic [FW-1:0] FIELD_LAST = FW'(NFIELD - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EDIT, S_COMMIT} state_e;

  state_e        state_q, state_d;
  logic [4:0]    btn_q;
  logic [4:0]    press;
  logic [FW-1:0] cursor_q, cursor_d;
  logic          edit_act;
  logic          move_l, move_r, moved;
  logic [1:0]    step;
  logic          load_en;
  logic [5:0]    sel_val;

  assign press   = btn & ~btn_q;
  assign load_en = (state_q == S_LOAD);

  // Edit actions need EDIT with enable high; a center press pre-empts all other buttons.
  assign edit_act = (state_q == S_EDIT) && enable && !press[0];
  assign move_r   = edit_act && press[2] && !press[1];
  assign move_l   = edit_act && press[1] && !press[2];
  assign moved    = move_l || move_r;

  // State, button history and cursor registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      btn_q    <= '0;
      cursor_q <= '0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn;
      cursor_q <= cursor_d;
    end
  end

  // Next state. In EDIT, a low enable aborts the edit before a center press can commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (press[0] && enable) state_d = S_LOAD;
      S_LOAD:   state_d = enable ? S_EDIT : S_IDLE;
      S_EDIT: begin
        if (!enable)       state_d = S_IDLE;
        else if (press[0]) state_d = S_COMMIT;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // The cursor resets on LOAD and wraps at both ends.
  always_comb begin
    cursor_d = cursor_q;
    if (load_en)
      cursor_d = '0;
    else if (move_r)
      cursor_d = (cursor_q == FIELD_LAST) ? '0 : cursor_q + FW'(1);
    else if (move_l)
      cursor_d = (cursor_q == '0) ? FIELD_LAST : cursor_q - FW'(1);
  end

  // Auto-repeat generator per direction: gi=0 up (btn[3]), gi=1 down (btn[4]).
  // A count of zero means idle. After a clear, a held button stays silent until it is pressed again.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rep
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rep_q, rep_d;
    logic          step_l;
    logic          clr;

    assign clr = !edit_act || moved || (btn[3] && btn[4]);

    // Repeat counter and repeat-phase flag.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
        rep_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        rep_q <= rep_d;
      end
    end

    // Step on the press edge. The first repeat comes DELAY cycles later, then one every RATE cycles.
    always_comb begin
      cnt_d  = cnt_q;
      rep_d  = rep_q;
      step_l = 1'b0;
      if (clr || !btn[3+gi]) begin
        cnt_d = '0;
        rep_d = 1'b0;
      end else if (press[3+gi]) begin
        step_l = 1'b1;
        cnt_d  = CW'(1);
        rep_d  = 1'b0;
      end else if (cnt_q != '0) begin
        if (cnt_q == (rep_q ? RATE_C : DELAY_C)) begin
          step_l = 1'b1;
          cnt_d  = CW'(1);
          rep_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    assign step[gi] = step_l;
  end

  assign sel_channel = CHW'(cursor_q >> 1);
  assign sel_is_min  = cursor_q[0];

  // Shadow registers for each channel, with out-of-range sanitising on load and wrap/carry on steps.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [4:0] hr_q, hr_d, hr_inc, hr_dec, hr_in_c;
    logic [5:0] mn_q, mn_d, mn_in_c;
    logic       sel_this;

    assign hr_in_c  = hours_in[5*gi +: 5];
    assign mn_in_c  = minutes_in[6*gi +: 6];
    assign sel_this = (sel_channel == CHW'(gi));
    assign hr_inc   = (hr_q == HOUR_LAST) ? 5'd0 : hr_q + 5'd1;
    assign hr_dec   = (hr_q == 5'd0) ? HOUR_LAST : hr_q - 5'd1;

    // Shadow hours/minutes storage.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        hr_q <= '0;
        mn_q <= '0;
      end else begin
        hr_q <= hr_d;
        mn_q <= mn_d;
      end
    end

    // Load from the inputs, or apply an up/down step when this channel is under the cursor.
    always_comb begin
      hr_d = hr_q;
      mn_d = mn_q;
      if (load_en) begin
        hr_d = ({1'b0, hr_in_c} >= HOUR_LIM) ? 5'd0 : hr_in_c;
        mn_d = (mn_in_c > 6'd59) ? 6'd0 : mn_in_c;
      end else if (sel_this && step[0]) begin
        if (!sel_is_min) begin
          hr_d = hr_inc;
        end else if (mn_q == 6'd59) begin
          mn_d = 6'd0;
          if (CARRY_EN != 0) hr_d = hr_inc;
        end else begin
          mn_d = mn_q + 6'd1;
        end
      end else if (sel_this && step[1]) begin
        if (!sel_is_min) begin
          hr_d = hr_dec;
        end else if (mn_q == 6'd0) begin
          mn_d = 6'd59;
          if (CARRY_EN != 0) hr_d = hr_dec;
        end else begin
          mn_d = mn_q - 6'd1;
        end
      end
    end

    assign hours_out[5*gi +: 5]   = hr_q;
    assign minutes_out[6*gi +: 6] = mn_q;
    assign dirty[gi]              = (hr_q != hr_in_c) || (mn_q != mn_in_c);
  end

  // Value under the cursor, split into BCD digits for the display mux.
  always_comb begin
    sel_val = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel_channel == CHW'(c))
        sel_val = sel_is_min ? minutes_out[6*c +: 6] : {1'b0, hours_out[5*c +: 5]};
    end
  end

  assign sel_tens  = 3'(sel_val / 6'd10);
  assign sel_units = 4'(sel_val % 6'd10);
  assign commit    = (state_q == S_COMMIT);
  assign led       = (state_q == S_EDIT) ? (NFIELD'(1) << cursor_q) : '0;

endmodule
